// File: rtl/nts_dispatcher_pkg.sv
// Shared definitions for the receive-side dispatcher: buffer/FSM encodings,
// counter width and a saturating increment.
package nts_dispatcher_defs;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FILLING = 2'd1,
        BUF_FULL    = 2'd2
    } buf_state_t;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_RECEIVE = 2'd1,
        WR_DROP    = 2'd2
    } wr_state_t;

    localparam int COUNTER_WIDTH = 32;

    function automatic logic [COUNTER_WIDTH-1:0] sat_inc(input logic [COUNTER_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/nts_dispatcher_ram.sv
// Ping-pong frame store: two 2^ADDR_WIDTH x 64 buffers in one simple dual-port
// RAM, buffer index in the address MSB. Registered read, no reset on the array.
module nts_dispatcher_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_WIDTH:0] wr_addr,
    input  logic [63:0]         wr_data,
    input  logic [ADDR_WIDTH:0] rd_addr,
    output logic [63:0]         rd_data
);

    logic [63:0] mem [2**(ADDR_WIDTH+1)];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/nts_dispatcher.sv
// MAC RX -> engine dispatcher: captures frames into ping-pong buffers, drops
// bad/oversized/unbufferable frames, presents complete frames as an FWFT FIFO.
//
// state      | meaning
// WR_IDLE    | between frames, waiting for a first word
// WR_RECEIVE | storing words of the current frame into buffer wr_sel
// WR_DROP    | discarding words until the frame's good/bad pulse
module nts_dispatcher
    import nts_dispatcher_defs::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                     i_clk,
    input  logic                     i_areset,
    input  logic [7:0]               i_mac_rx_data_valid,
    input  logic [63:0]              i_mac_rx_data,
    input  logic                     i_mac_rx_good_frame,
    input  logic                     i_mac_rx_bad_frame,
    output logic                     o_dispatch_packet_available,
    input  logic                     i_dispatch_packet_read_discard,
    output logic [7:0]               o_dispatch_data_valid,
    output logic                     o_dispatch_fifo_empty,
    input  logic                     i_dispatch_fifo_rd_en,
    output logic [63:0]              o_dispatch_fifo_rd_data,
    output logic [COUNTER_WIDTH-1:0] o_dropped_count
);

    localparam logic [ADDR_WIDTH:0] BUF_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

    buf_state_t              buf_state [2];
    logic [ADDR_WIDTH:0]     buf_count [2];
    logic [7:0]              buf_mask  [2];
    logic                    wr_sel;
    logic                    rd_sel;
    logic                    prefetch;
    logic                    resync;
    logic [ADDR_WIDTH:0]     rp;
    wr_state_t               wr_state;
    wr_state_t               wr_next;
    logic [COUNTER_WIDTH-1:0] dropped_count;

    logic word, start, append, commit, abort, count_drop;
    logic available, fifo_empty, pop, discard;
    logic                  ram_wr_en;
    logic [ADDR_WIDTH:0]   ram_wr_addr;
    logic [ADDR_WIDTH:0]   ram_rd_addr;
    logic [63:0]           ram_rd_data;

    // Words seen before the first frame boundary after reset belong to a lost frame.
    assign word = (i_mac_rx_data_valid != 8'h00) && !resync;

    always_comb begin
        wr_next    = wr_state;
        start      = 1'b0;
        append     = 1'b0;
        commit     = 1'b0;
        abort      = 1'b0;
        count_drop = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                if (word) begin
                    if (buf_state[wr_sel] == BUF_EMPTY) begin
                        start   = 1'b1;
                        wr_next = WR_RECEIVE;
                    end else begin
                        wr_next = WR_DROP;
                    end
                end
            end
            WR_RECEIVE: begin
                if (i_mac_rx_good_frame) begin
                    commit  = 1'b1;
                    wr_next = WR_IDLE;
                end else if (i_mac_rx_bad_frame) begin
                    abort      = 1'b1;
                    count_drop = 1'b1;
                    wr_next    = WR_IDLE;
                end else if (word) begin
                    if (buf_count[wr_sel] == BUF_WORDS) begin
                        abort   = 1'b1;
                        wr_next = WR_DROP;
                    end else begin
                        append = 1'b1;
                    end
                end
            end
            WR_DROP: begin
                if (i_mac_rx_good_frame || i_mac_rx_bad_frame) begin
                    count_drop = 1'b1;
                    wr_next    = WR_IDLE;
                end
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    assign available  = (buf_state[rd_sel] == BUF_FULL) && !prefetch;
    assign fifo_empty = !available || (rp == buf_count[rd_sel]);
    assign pop        = i_dispatch_fifo_rd_en && !fifo_empty;
    assign discard    = i_dispatch_packet_read_discard && available;

    assign ram_wr_en   = start || append;
    assign ram_wr_addr = {wr_sel, start ? {ADDR_WIDTH{1'b0}} : buf_count[wr_sel][ADDR_WIDTH-1:0]};
    // Look one word ahead on a pop so the registered port keeps showing word rp.
    assign ram_rd_addr = {rd_sel, rp[ADDR_WIDTH-1:0] + {{(ADDR_WIDTH-1){1'b0}}, pop}};

    always_ff @(posedge i_clk) begin
        if (i_areset) begin
            wr_state      <= WR_IDLE;
            buf_state[0]  <= BUF_EMPTY;
            buf_state[1]  <= BUF_EMPTY;
            buf_count[0]  <= '0;
            buf_count[1]  <= '0;
            buf_mask[0]   <= '0;
            buf_mask[1]   <= '0;
            wr_sel        <= 1'b0;
            rd_sel        <= 1'b0;
            rp            <= '0;
            prefetch      <= 1'b0;
            resync        <= 1'b1;
            dropped_count <= '0;
        end else begin
            wr_state <= wr_next;
            if (i_mac_rx_good_frame || i_mac_rx_bad_frame) begin
                resync <= 1'b0;
            end
            if (start) begin
                buf_state[wr_sel] <= BUF_FILLING;
                buf_count[wr_sel] <= {{ADDR_WIDTH{1'b0}}, 1'b1};
                buf_mask[wr_sel]  <= i_mac_rx_data_valid;
            end
            if (append) begin
                buf_count[wr_sel] <= buf_count[wr_sel] + 1'b1;
                buf_mask[wr_sel]  <= i_mac_rx_data_valid;
            end
            if (commit) begin
                buf_state[wr_sel] <= BUF_FULL;
                wr_sel            <= ~wr_sel;
            end
            if (abort) begin
                buf_state[wr_sel] <= BUF_EMPTY;
            end
            if (count_drop) begin
                dropped_count <= sat_inc(dropped_count);
            end
            // Discard only hits a FULL read buffer, never the one being written.
            prefetch <= discard;
            if (discard) begin
                buf_state[rd_sel] <= BUF_EMPTY;
                rd_sel            <= ~rd_sel;
                rp                <= '0;
            end else if (pop) begin
                rp <= rp + 1'b1;
            end
        end
    end

    nts_dispatcher_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (i_clk),
        .wr_en   (ram_wr_en),
        .wr_addr (ram_wr_addr),
        .wr_data (i_mac_rx_data),
        .rd_addr (ram_rd_addr),
        .rd_data (ram_rd_data)
    );

    assign o_dispatch_packet_available = available;
    assign o_dispatch_fifo_empty       = fifo_empty;
    assign o_dispatch_data_valid       = available ? buf_mask[rd_sel] : 8'h00;
    assign o_dispatch_fifo_rd_data     = available ? ram_rd_data : 64'h0;
    assign o_dropped_count             = dropped_count;

endmodule

// File: tb/tb_nts_dispatcher.sv
// Directed bench for nts_dispatcher (ADDR_WIDTH = 4): frame delivery, drops,
// overflow, over-read, back-to-back frames and mid-frame reset.
module tb_nts_dispatcher;

    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  rx_valid = 8'h00;
    logic [63:0] rx_data = 64'h0;
    logic        good = 1'b0;
    logic        bad = 1'b0;
    logic        avail;
    logic        discard = 1'b0;
    logic [7:0]  dvalid;
    logic        fempty;
    logic        rd_en = 1'b0;
    logic [63:0] rdata;
    logic [31:0] dropped;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    nts_dispatcher #(.ADDR_WIDTH(AW)) dut (
        .i_clk                          (clk),
        .i_areset                       (areset),
        .i_mac_rx_data_valid            (rx_valid),
        .i_mac_rx_data                  (rx_data),
        .i_mac_rx_good_frame            (good),
        .i_mac_rx_bad_frame             (bad),
        .o_dispatch_packet_available    (avail),
        .i_dispatch_packet_read_discard (discard),
        .o_dispatch_data_valid          (dvalid),
        .o_dispatch_fifo_empty          (fempty),
        .i_dispatch_fifo_rd_en          (rd_en),
        .o_dispatch_fifo_rd_data        (rdata),
        .o_dropped_count                (dropped)
    );

    function automatic logic [63:0] word_of(input logic [31:0] base, input int i);
        return {base, 32'(i)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [31:0] base, input int n, input logic [7:0] last_mask,
                              input bit is_good);
        for (int i = 0; i < n; i++) begin
            rx_valid = (i == n - 1) ? last_mask : 8'hff;
            rx_data  = word_of(base, i);
            tick();
        end
        rx_valid = 8'h00;
        rx_data  = 64'h0;
        good     = is_good;
        bad      = !is_good;
        tick();
        good = 1'b0;
        bad  = 1'b0;
    endtask

    task automatic pulse_discard();
        discard = 1'b1;
        tick();
        discard = 1'b0;
    endtask

    // Pops n words, checking each head word, then checks the FIFO reads empty.
    task automatic drain(input logic [31:0] base, input int n, input string name);
        for (int i = 0; i < n; i++) begin
            vectors++;
            if (fempty !== 1'b0 || rdata !== word_of(base, i)) begin
                miscompares++;
                $display("FAIL %s word %0d: got data=%h empty=%b, want data=%h empty=0",
                         name, i, rdata, fempty, word_of(base, i));
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        vectors++;
        if (fempty !== 1'b1) begin
            miscompares++;
            $display("FAIL %s empty after drain: got %b, want 1", name, fempty);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        vectors++;
        if (avail !== 1'b0) begin miscompares++; $display("FAIL reset available: got %b, want 0", avail); end
        vectors++;
        if (fempty !== 1'b1) begin miscompares++; $display("FAIL reset fifo_empty: got %b, want 1", fempty); end
        vectors++;
        if (dvalid !== 8'h00) begin miscompares++; $display("FAIL reset data_valid: got %h, want 00", dvalid); end
        vectors++;
        if (rdata !== 64'h0) begin miscompares++; $display("FAIL reset rd_data: got %h, want 0", rdata); end
        // A bare frame boundary resynchronises the write side; it is not a drop.
        good = 1'b1;
        tick();
        good = 1'b0;
        vectors++;
        if (dropped !== 32'd0) begin miscompares++; $display("FAIL reset dropped_count: got %0d, want 0", dropped); end
    endtask

    task automatic test_single_frame();
        send_frame(32'hA000_0000, 8, 8'h0f, 1'b1);
        vectors++;
        if (avail !== 1'b1 || fempty !== 1'b0 || rdata !== word_of(32'hA000_0000, 0)) begin
            miscompares++;
            $display("FAIL single t+1: got avail=%b empty=%b data=%h, want 1 0 %h",
                     avail, fempty, rdata, word_of(32'hA000_0000, 0));
        end
        drain(32'hA000_0000, 8, "single");
        vectors++;
        if (dvalid !== 8'h0f || avail !== 1'b1) begin
            miscompares++;
            $display("FAIL single data_valid/avail: got %h/%b, want 0f/1", dvalid, avail);
        end
        pulse_discard();
        vectors++;
        if (avail !== 1'b0) begin miscompares++; $display("FAIL single discard avail: got %b, want 0", avail); end
    endtask

    task automatic test_back_to_back();
        send_frame(32'hB000_0000, 5, 8'hff, 1'b1);
        send_frame(32'hC000_0000, 4, 8'h3f, 1'b1);
        vectors++;
        if (avail !== 1'b1 || rdata !== word_of(32'hB000_0000, 0) || dvalid !== 8'hff) begin
            miscompares++;
            $display("FAIL b2b first frame: got avail=%b data=%h dv=%h, want 1 %h ff",
                     avail, rdata, dvalid, word_of(32'hB000_0000, 0));
        end
        send_frame(32'hD000_0000, 3, 8'hff, 1'b1);
        vectors++;
        if (dropped !== 32'd1) begin miscompares++; $display("FAIL b2b dropped_count: got %0d, want 1", dropped); end
        pulse_discard();
        vectors++;
        if (avail !== 1'b0) begin miscompares++; $display("FAIL b2b prefetch avail: got %b, want 0", avail); end
        tick();
        vectors++;
        if (avail !== 1'b1 || rdata !== word_of(32'hC000_0000, 0) || dvalid !== 8'h3f) begin
            miscompares++;
            $display("FAIL b2b second frame t+2: got avail=%b data=%h dv=%h, want 1 %h 3f",
                     avail, rdata, dvalid, word_of(32'hC000_0000, 0));
        end
        drain(32'hC000_0000, 4, "b2b");
        pulse_discard();
        tick();
        vectors++;
        if (avail !== 1'b0 || fempty !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b nothing left: got avail=%b empty=%b, want 0 1", avail, fempty);
        end
    endtask

    task automatic test_bad_frame();
        send_frame(32'hE000_0000, 3, 8'hff, 1'b0);
        vectors++;
        if (avail !== 1'b0 || fempty !== 1'b1 || dropped !== 32'd2) begin
            miscompares++;
            $display("FAIL bad frame: got avail=%b empty=%b dropped=%0d, want 0 1 2", avail, fempty, dropped);
        end
        send_frame(32'hF000_0000, 2, 8'h03, 1'b1);
        vectors++;
        if (avail !== 1'b1 || dvalid !== 8'h03) begin
            miscompares++;
            $display("FAIL bad frame reuse: got avail=%b dv=%h, want 1 03", avail, dvalid);
        end
        drain(32'hF000_0000, 2, "reuse");
        pulse_discard();
    endtask

    task automatic test_overflow();
        send_frame(32'h1700_0000, 17, 8'hff, 1'b1);
        vectors++;
        if (avail !== 1'b0 || dropped !== 32'd3) begin
            miscompares++;
            $display("FAIL overflow drop: got avail=%b dropped=%0d, want 0 3", avail, dropped);
        end
        send_frame(32'h1600_0000, 16, 8'hf0, 1'b1);
        vectors++;
        if (avail !== 1'b1 || dvalid !== 8'hf0 || dropped !== 32'd3) begin
            miscompares++;
            $display("FAIL full-size frame: got avail=%b dv=%h dropped=%0d, want 1 f0 3", avail, dvalid, dropped);
        end
        drain(32'h1600_0000, 16, "fullsize");
        pulse_discard();
    endtask

    // Buffer 1 is preloaded with a 6-word frame so the word past a 3-word
    // frame is known: when empty, rd_data shows word rp (= count).
    task automatic test_over_read();
        send_frame(32'h3300_0000, 6, 8'hff, 1'b1);
        pulse_discard();
        send_frame(32'h4400_0000, 2, 8'hff, 1'b1);
        pulse_discard();
        send_frame(32'h5500_0000, 3, 8'h07, 1'b1);
        drain(32'h5500_0000, 3, "overread");
        vectors++;
        if (rdata !== word_of(32'h3300_0000, 3)) begin
            miscompares++;
            $display("FAIL overread head at empty: got %h, want %h", rdata, word_of(32'h3300_0000, 3));
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
        vectors++;
        if (rdata !== word_of(32'h3300_0000, 3) || fempty !== 1'b1 || avail !== 1'b1) begin
            miscompares++;
            $display("FAIL overread held: got data=%h empty=%b avail=%b, want %h 1 1",
                     rdata, fempty, avail, word_of(32'h3300_0000, 3));
        end
        pulse_discard();
        tick();
        vectors++;
        if (avail !== 1'b0 || fempty !== 1'b1 || dvalid !== 8'h00) begin
            miscompares++;
            $display("FAIL overread discard: got avail=%b empty=%b dv=%h, want 0 1 00", avail, fempty, dvalid);
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(32'h7000_0000, 3, 8'hff, 1'b1);
        for (int i = 0; i < 8; i++) begin
            rx_valid = 8'hff;
            rx_data  = word_of(32'h8000_0000, i);
            areset   = (i == 4);
            tick();
            areset = 1'b0;
            if (i == 4) begin
                vectors++;
                if (avail !== 1'b0 || fempty !== 1'b1 || dvalid !== 8'h00 || rdata !== 64'h0 || dropped !== 32'd0) begin
                    miscompares++;
                    $display("FAIL midreset outputs: got avail=%b empty=%b dv=%h data=%h dropped=%0d, want 0 1 00 0 0",
                             avail, fempty, dvalid, rdata, dropped);
                end
            end
        end
        rx_valid = 8'h00;
        rx_data  = 64'h0;
        good     = 1'b1;
        tick();
        good = 1'b0;
        vectors++;
        if (avail !== 1'b0 || dropped !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset tail ignored: got avail=%b dropped=%0d, want 0 0", avail, dropped);
        end
        send_frame(32'h9000_0000, 4, 8'h1f, 1'b1);
        vectors++;
        if (avail !== 1'b1 || dvalid !== 8'h1f || dropped !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset next frame: got avail=%b dv=%h dropped=%0d, want 1 1f 0", avail, dvalid, dropped);
        end
        drain(32'h9000_0000, 4, "midreset");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_bad_frame();
        test_overflow();
        test_over_read();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nts_dispatcher.md
# nts_dispatcher

Receive-side dispatcher between the 10G MAC RX stream and `nts_engine`. It captures one Ethernet frame at a time into a ping-pong pair of word buffers and drops bad, oversized or unbufferable frames. It then presents each completed frame to the engine through a first-word-fall-through (FWFT) FIFO-style interface, with a per-frame last-word byte mask. The engine releases a frame with a discard pulse, which frees the buffer for the MAC side.

## Interface
- `ADDR_WIDTH`, 10: log2 of words per buffer; each buffer holds 2^ADDR_WIDTH 64-bit words.
- `i_clk` in 1: single clock for MAC side and engine side.
- `i_areset` in 1: reset, synchronous and active-high.
- `i_mac_rx_data_valid` in 8: byte mask of the current MAC word; 0 means no word. Only the last word of a frame may have a mask other than 0xff.
- `i_mac_rx_data` in 64: MAC word, byte 0 in bits 63:56.
- `i_mac_rx_good_frame` in 1: one-cycle pulse after the last word; the frame is valid.
- `i_mac_rx_bad_frame` in 1: one-cycle pulse after the last word; the frame is corrupt.
- `o_dispatch_packet_available` out 1: a complete frame is held in the read buffer.
- `i_dispatch_packet_read_discard` in 1: one-cycle pulse; release the read buffer.
- `o_dispatch_data_valid` out 8: byte mask of the last word of the presented frame.
- `o_dispatch_fifo_empty` out 1: no unread words remain in the presented frame.
- `i_dispatch_fifo_rd_en` in 1: pop the head word.
- `o_dispatch_fifo_rd_data` out 64: head word; valid while `o_dispatch_fifo_empty` = 0.
- `o_dropped_count` out 32: saturating count of dropped frames.

## Operation
- **Buffer states.** Each of the two buffers (index 0/1) is EMPTY, FILLING or FULL. Per buffer, hold a word count (ADDR_WIDTH+1 bits) and the last-word mask (8 bits).
- **Write FSM (IDLE, RECEIVE, DROP).**
  - IDLE, first word arrives (mask ≠ 0):
    - If `wr_sel`'s buffer is EMPTY: write the word at address 0, count = 1, buffer → FILLING, go to RECEIVE.
    - Otherwise: go to DROP.
  - RECEIVE, word arrives:
    - If count = 2^ADDR_WIDTH (overflow): buffer → EMPTY, go to DROP.
    - Otherwise: write the word at address count, count++, and latch its mask.
  - RECEIVE, good_frame: buffer → FULL, toggle `wr_sel`, go to IDLE.
  - RECEIVE, bad_frame: buffer → EMPTY, increment drop count, go to IDLE.
  - DROP: ignore words. On good_frame or bad_frame, increment drop count and go to IDLE.
  - IDLE, good_frame or bad_frame with no words received: ignored, not counted.
- **Read side.** `rd_sel` selects the presented buffer.
  - `o_dispatch_packet_available` = (buffer[rd_sel] is FULL) and the read side is not in its one-cycle prefetch.
  - Read pointer `rp` runs from 0 to count. `o_dispatch_fifo_empty` = (`rp` = count) or not available.
  - A pop while not empty increments `rp`. A pop while empty is ignored: no pointer change, rd_data is held.
  - Discard pulse: buffer[rd_sel] → EMPTY, toggle `rd_sel`, `rp` = 0, enter prefetch. A discard when nothing is available is ignored.
- **FWFT read.** The RAM has a registered read port. Read address = `{rd_sel, rd_en && !empty ? rp+1 : rp}`, so rd_data always shows word `rp`.
- **Simultaneous events.**
  - good_frame on one buffer and discard on the other in the same cycle: both take effect.
  - FILLING → FULL and a read-side switch onto that same buffer in the same cycle: allowed; it appears after prefetch.
- **Drop counter.** 32 bits, saturates at 0xffffffff.
- **Reset** (synchronous, takes effect at the clock edge):
  - Both buffers EMPTY; `wr_sel` = `rd_sel` = 0; `rp` = 0; write FSM IDLE.
  - Outputs: available = 0, fifo_empty = 1, data_valid = 0, rd_data = 0, dropped_count = 0.
  - A frame being received when reset is asserted is lost and not counted. The MAC stream after reset is ignored until the next good_frame/bad_frame, then treated normally.

## Timing
- **good_frame at cycle t:**
  - If the buffer is the read buffer: available = 1 and empty = 0 at t+1, rd_data = word 0 at t+1.
  - If it is the other buffer: it is presented only after the current frame is discarded.
- **Discard at cycle t:** available = 0 at t+1 (prefetch cycle). If the other buffer is FULL, available = 1 and rd_data = word 0 at t+2.
- **Pops:** back-to-back pops at one word per cycle. The popped word is valid in the same cycle as rd_en; the next word is valid at the next cycle.
- **Write path:** one word per cycle, no backpressure to the MAC.

## Structure
- A shared `nts_dispatcher_defs` header holds:
  - buffer state encodings (EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2);
  - write FSM encodings;
  - the counter width constant (32).
- One sub-module, `nts_dispatcher_ram`: a simple dual-port RAM of 2^(ADDR_WIDTH+1) × 64 bits, with one write port, one registered read port and no reset on the array.

## Test plan
- 8-word frame with last mask 0x0f, then good_frame → available at t+1. The engine pops 8 words, which match the input. Empty = 1 after the 8th pop, data_valid = 0x0f.
- Two frames back-to-back, both good, no discard, then a third frame → third frame dropped, dropped_count = 1. Discard → frame 2 available 2 cycles later.
- 3-word frame ending in bad_frame → never available, dropped_count = 1, buffer reusable by the next frame.
- ADDR_WIDTH = 4, 17-word frame → dropped, count = 1. A following 16-word frame is delivered intact.
- Pop issued while empty (engine over-read) → rd_data and pointer unchanged. Discard then behaves normally.
- Reset asserted mid-frame at word 5 → outputs at reset values the next cycle. That frame's remaining words and its good_frame are ignored. The next frame is delivered normally.
